i2c_target_regs: RTL and testbench

I2C target (slave) register bank: the responder end for the team's i2c_init master.
- Lets the i2c_init sequence run against a camera-like target in simulation and on FPGA loopback.
- Holds 2^REG_AW byte registers. Supports pointer-write, data-write with auto-increment, and read with auto-increment.
- Runs entirely on the system clock. SCL and SDA are oversampled, never used as clocks.

---
 rtl/i2c_target_regs.sv | 241 ++++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target register bank: oversampled SCL/SDA, pointer write, auto-increment write/read.
// Optional macro I2C_GLITCH_FILTER_EN adds a 3-sample glitch filter after the synchroniser.
`timescale 1ns/1ps
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h58,
  parameter int         REG_AW   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              wr_stb,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_t;

  logic scl_p0, scl_p1, scl_p2, sda_p0, sda_p1, sda_p2;
  logic scl_f, sda_f;

  // p0/p1: synchroniser, idle bus level out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
    end else begin
      scl_p0 <= scl;
      scl_p1 <= scl_p0;
      sda_p0 <= sda_in;
      sda_p1 <= sda_p0;
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_p1};
      sda_hist <= {sda_hist[0], sda_p1};
      if (scl_p1 == scl_hist[0] && scl_p1 == scl_hist[1]) scl_f <= scl_p1;
      if (sda_p1 == sda_hist[0] && sda_p1 == sda_hist[1]) sda_f <= sda_p1;
    end
  end
`else
  assign scl_f = scl_p1;
  assign sda_f = sda_p1;
`endif

  // p2: previous sample for edge and bus-condition detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_p2 <= 1'b1;
      sda_p2 <= 1'b1;
    end else begin
      scl_p2 <= scl_f;
      sda_p2 <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_f & ~scl_p2;
  assign scl_fall  = ~scl_f & scl_p2;
  assign start_det = scl_f & scl_p2 & sda_p2 & ~sda_f;
  assign stop_det  = scl_f & scl_p2 & ~sda_p2 & sda_f;

  state_t              state, state_n;
  logic [2:0]          cnt, cnt_n;
  logic [7:0]          shreg, shreg_n;
  logic [REG_AW-1:0]   ptr, ptr_n, ptr_inc;
  logic                rw, rw_n, phase, phase_n;
  logic                sda_oe_n, busy_n, wr_stb_n;
  logic [REG_AW-1:0]   wr_addr_n;
  logic [7:0]          wr_data_n;
  logic [7:0]          regs [2**REG_AW];
  logic [7:0]          byte_in;

  assign byte_in = {shreg[6:0], sda_f};
  assign ptr_inc = ptr + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      shreg   <= '0;
      ptr     <= '0;
      rw      <= 1'b0;
      phase   <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      shreg   <= shreg_n;
      ptr     <= ptr_n;
      rw      <= rw_n;
      phase   <= phase_n;
      sda_oe  <= sda_oe_n;
      busy    <= busy_n;
      wr_stb  <= wr_stb_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
    end else if (wr_stb_n) begin
      regs[ptr] <= byte_in;
    end
  end

  // phase: in ACK states marks "ACK already driven"; in RDATA_ACK marks "next byte loaded"
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shreg_n   = shreg;
    ptr_n     = ptr;
    rw_n      = rw;
    phase_n   = phase;
    sda_oe_n  = sda_oe;
    busy_n    = busy;
    wr_stb_n  = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    if (stop_det) begin
      state_n  = S_IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
      phase_n  = 1'b0;
    end else if (start_det) begin
      state_n  = S_DEV_ADDR;
      cnt_n    = '0;
      sda_oe_n = 1'b0;
      phase_n  = 1'b0;
    end else begin
      case (state)
        S_IDLE: ;
        S_DEV_ADDR: if (scl_rise) begin
          shreg_n = byte_in;
          cnt_n   = cnt + 3'd1;
          if (cnt == 3'd7) begin
            rw_n    = sda_f;
            phase_n = 1'b0;
            if (byte_in[7:1] == DEV_ADDR) begin
              state_n = S_DEV_ACK;
              busy_n  = 1'b1;
            end else begin
              state_n = S_IGNORE;
            end
          end
        end
        S_PTR: if (scl_rise) begin
          shreg_n = byte_in;
          cnt_n   = cnt + 3'd1;
          if (cnt == 3'd7) begin
            ptr_n   = byte_in[REG_AW-1:0];
            state_n = S_PTR_ACK;
          end
        end
        S_WDATA: if (scl_rise) begin
          shreg_n = byte_in;
          cnt_n   = cnt + 3'd1;
          if (cnt == 3'd7) begin
            wr_stb_n  = 1'b1;
            wr_addr_n = ptr;
            wr_data_n = byte_in;
            ptr_n     = ptr_inc;
            state_n   = S_WDATA_ACK;
          end
        end
        S_DEV_ACK, S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
          if (!phase) begin
            sda_oe_n = 1'b1;
            phase_n  = 1'b1;
          end else begin
            phase_n  = 1'b0;
            cnt_n    = '0;
            sda_oe_n = 1'b0;
            if (state == S_DEV_ACK && rw) begin
              state_n  = S_RDATA;
              shreg_n  = regs[ptr];
              sda_oe_n = ~regs[ptr][7];
            end else if (state == S_DEV_ACK) begin
              state_n = S_PTR;
            end else begin
              state_n = S_WDATA;
            end
          end
        end
        S_RDATA: if (scl_fall) begin
          if (cnt == 3'd7) begin
            sda_oe_n = 1'b0;
            phase_n  = 1'b0;
            state_n  = S_RDATA_ACK;
          end else begin
            shreg_n  = {shreg[6:0], 1'b0};
            sda_oe_n = ~shreg[6];
            cnt_n    = cnt + 3'd1;
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise && !phase) begin
            if (!sda_f) begin
              ptr_n   = ptr_inc;
              shreg_n = regs[ptr_inc];
              phase_n = 1'b1;
            end else begin
              state_n = S_IGNORE;
            end
          end else if (scl_fall && phase) begin
            sda_oe_n = ~shreg[7];
            cnt_n    = '0;
            phase_n  = 1'b0;
            state_n  = S_RDATA;
          end
        end
        S_IGNORE: sda_oe_n = 1'b0;
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master with queued expectations for
// target-driven bus bits and register-write strobes.
`timescale 1ns/1ps
module tb_i2c_target_regs;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, wr_stb, busy;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  always #5 clk = ~clk;
  assign sda_line = sda_m & ~sda_oe;

  i2c_target_regs dut (
    .clk     (clk),
    .reset   (reset),
    .scl     (scl),
    .sda_in  (sda_line),
    .sda_oe  (sda_oe),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  typedef struct packed { logic v; logic [7:0] tag; } bit_exp_t;
  typedef struct packed { logic [3:0] a; logic [7:0] d; } wr_exp_t;

  bit_exp_t bit_q[$];
  wr_exp_t  wr_q[$];
  int       checks = 0;
  int       errors = 0;
  logic     slot = 1'b0;
  logic     quiet = 1'b0;
  int       quiet_viol = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    tick(8); sda_m = b;
    tick(8); scl = 1'b1;
    tick(10); scl = 1'b0;
  endtask

  task automatic tgt_slot(input logic exp, input logic [7:0] tag);
    tick(8); sda_m = 1'b1; slot = 1'b1;
    bit_q.push_back({exp, tag});
    tick(8); scl = 1'b1;
    tick(10); scl = 1'b0; slot = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    tgt_slot(exp_ack, b);
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic mack);
    for (int i = 7; i >= 0; i--) tgt_slot(exp[i], exp);
    send_bit(mack);
  endtask

  task automatic start_cond();
    if (scl) begin
      sda_m = 1'b0; tick(10); scl = 1'b0;
    end else begin
      tick(8); sda_m = 1'b1;
      tick(8); scl = 1'b1;
      tick(10); sda_m = 1'b0;
      tick(10); scl = 1'b0;
    end
  endtask

  task automatic stop_cond();
    tick(8); sda_m = 1'b0;
    tick(8); scl = 1'b1;
    tick(10); sda_m = 1'b1;
    tick(10);
  endtask

  // Bus monitor: samples the line mid-high-phase of every target-owned bit
  always @(posedge scl) begin : mon_bus
    bit_exp_t e;
    if (slot) begin
      repeat (5) @(negedge clk);
      checks++;
      if (bit_q.size() == 0) begin
        errors++;
        $display("FAIL bus_bit_unexpected: actual %b required none queued", sda_line);
      end else begin
        e = bit_q.pop_front();
        if (sda_line !== e.v) begin
          errors++;
          $display("FAIL bus_bit tag=%02h: actual %b required %b", e.tag, sda_line, e.v);
        end
      end
    end
  end

  // Write-strobe monitor: one expectation consumed per strobe cycle
  always @(negedge clk) begin : mon_wr
    wr_exp_t w;
    if (!reset && wr_stb) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL wr_stb_unexpected: actual addr %0h data %02h required no strobe", wr_addr, wr_data);
      end else begin
        w = wr_q.pop_front();
        if (wr_addr !== w.a || wr_data !== w.d) begin
          errors++;
          $display("FAIL wr_stb: actual addr %0h data %02h required addr %0h data %02h",
                   wr_addr, wr_data, w.a, w.d);
        end
      end
    end
  end

  always @(negedge clk) if (quiet && (sda_oe || busy || wr_stb)) quiet_viol++;

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_wr_stb", 32'(wr_stb), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick(5);

    // Single write, pointer 0x30 truncates to 0
    start_cond();
    send_byte(8'hB0, 1'b0);
    check("busy_after_addr", 32'(busy), 32'd1);
    send_byte(8'h30, 1'b0);
    wr_q.push_back({4'h0, 8'h01});
    send_byte(8'h01, 1'b0);
    stop_cond(); tick(6);
    check("busy_after_stop1", 32'(busy), 32'd0);

    // Read back reg[0]
    start_cond();
    send_byte(8'hB0, 1'b0);
    send_byte(8'h30, 1'b0);
    start_cond();
    send_byte(8'hB1, 1'b0);
    read_byte(8'h01, 1'b1);
    stop_cond(); tick(6);

    // Burst write with pointer wrap
    start_cond();
    send_byte(8'hB0, 1'b0);
    send_byte(8'h0E, 1'b0);
    wr_q.push_back({4'hE, 8'hAA}); send_byte(8'hAA, 1'b0);
    wr_q.push_back({4'hF, 8'hBB}); send_byte(8'hBB, 1'b0);
    wr_q.push_back({4'h0, 8'hCC}); send_byte(8'hCC, 1'b0);
    stop_cond(); tick(6);
    check("busy_after_burst", 32'(busy), 32'd0);

    // Pointer write, repeated START, read with ACK then NACK
    start_cond();
    send_byte(8'hB0, 1'b0);
    send_byte(8'h0E, 1'b0);
    start_cond();
    send_byte(8'hB1, 1'b0);
    read_byte(8'hAA, 1'b0);
    read_byte(8'hBB, 1'b1);
    tick(6);
    check("sda_after_nack", 32'(sda_oe), 32'd0);
    stop_cond(); tick(6);
    check("busy_after_read", 32'(busy), 32'd0);

    // Foreign address: no ACK, no strobe, never busy
    quiet = 1'b1;
    start_cond();
    send_byte(8'h42, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    stop_cond(); tick(6);
    quiet = 1'b0;
    check("foreign_addr_quiet", 32'(quiet_viol), 32'd0);

    // One-clock SDA glitch while SCL high
    tick(10);
    sda_m = 1'b0; tick(1); sda_m = 1'b1;
    tick(12);
    check("glitch_busy", 32'(busy), 32'd0);
    check("glitch_sda_oe", 32'(sda_oe), 32'd0);

    // Reset while the target drives the address ACK
    start_cond();
    for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 5 || i == 4);
    tick(8); sda_m = 1'b1;
    tick(8); scl = 1'b1;
    tick(3);
    check("ack_driven", 32'(sda_oe), 32'd1);
    check("busy_in_ack", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("reset_releases_sda", 32'(sda_oe), 32'd0);
    check("reset_clears_busy", 32'(busy), 32'd0);
    @(negedge clk); reset = 1'b0;
    tick(6); scl = 1'b0;
    stop_cond(); tick(6);
    check("busy_after_reset", 32'(busy), 32'd0);

    // Registers cleared: reg[14], reg[15] read back as zero
    start_cond();
    send_byte(8'hB0, 1'b0);
    send_byte(8'h0E, 1'b0);
    start_cond();
    send_byte(8'hB1, 1'b0);
    read_byte(8'h00, 1'b0);
    read_byte(8'h00, 1'b1);
    stop_cond(); tick(10);

    check("bit_queue_drained", 32'(bit_q.size()), 32'd0);
    check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
